// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM state type, timing constants and counter sizing helper for the ADC sampler.
package adc_pkg;
   typedef enum logic [2:0] {ST_RST, ST_IDLE, ST_CONV, ST_WAIT_BUSY, ST_RD_LO, ST_RD_HI} state_t;
   localparam int RST_CYC = 4;
   localparam int CONVST_CYC = 2;
   function automatic int cnt_w(input int a, input int b);
      return $clog2((a > b ? a : b) + 1);
   endfunction
endpackage

// File: rtl/adc_par_sampler_if.sv
// adc_par_sampler_if: valid/ready sample stream carrying one ADC channel word per transfer.
interface adc_par_sampler_if #(
   parameter int DATA_W = 16,
   parameter int CH_W = 3
);
   logic [DATA_W-1:0] data;
   logic [CH_W-1:0] chan;
   logic last;
   logic valid;
   logic ready;
   modport master(output data, chan, last, valid, input ready);
   modport slave(input data, chan, last, valid, output ready);
endinterface

// File: rtl/adc_rate_tick.sv
// adc_rate_tick: free-running period counter that pulses tick at each wrap while enabled.
module adc_rate_tick #(
   parameter int PERIOD = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);
   localparam int W = $clog2(PERIOD);
   logic [W-1:0] cnt;
   logic wrap;
   assign wrap = cnt == W'(PERIOD - 1);
   assign tick = enable && wrap;
   always_ff @(posedge clk)
      if (rst || !enable) cnt <= '0;
      else cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/adc_par_sampler.sv
// adc_par_sampler: periodic parallel-ADC conversion/readout FSM feeding a valid/ready sample stream.
module adc_par_sampler
   import adc_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 16,
   parameter int CONV_PERIOD = 1000,
   parameter int RD_CYC = 4,
   parameter int BUSY_TO = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [2:0]        os_sel,
   input  logic [DATA_W-1:0] ad_data,
   input  logic              ad_busy,
   input  logic              ad_first_data,
   output logic [2:0]        ad_os,
   output logic              ad_reset,
   output logic              ad_convst,
   output logic              ad_cs,
   output logic              ad_rd,
   adc_par_sampler_if.master m,
   output logic              overrun,
   output logic              frame_err
);
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int CW = cnt_w(BUSY_TO, RD_CYC > RST_CYC ? RD_CYC : RST_CYC);
   state_t state;
   logic [CW-1:0] cyc;
   logic [CH_W-1:0] chan;
   logic seen_busy;
   logic tick;
   logic stall;
   assign stall = m.valid && !m.ready;
   adc_rate_tick #(.PERIOD(CONV_PERIOD)) u_tick (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .tick(tick)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_RST;
         cyc <= '0;
         chan <= '0;
         seen_busy <= 1'b0;
         ad_reset <= 1'b1;
         ad_convst <= 1'b1;
         ad_cs <= 1'b1;
         ad_rd <= 1'b1;
         ad_os <= '0;
         m.valid <= 1'b0;
         m.data <= '0;
         m.chan <= '0;
         m.last <= 1'b0;
         overrun <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (m.valid && m.ready) m.valid <= 1'b0;
         if (tick && state != ST_IDLE) overrun <= 1'b1;
         case (state)
            ST_RST: begin
               cyc <= cyc + 1'b1;
               if (cyc == CW'(RST_CYC - 1)) begin
                  ad_reset <= 1'b0;
                  cyc <= '0;
                  state <= ST_IDLE;
               end
            end
            ST_IDLE:
               if (tick) begin
                  ad_os <= os_sel;
                  ad_convst <= 1'b0;
                  cyc <= '0;
                  state <= ST_CONV;
               end
            ST_CONV: begin
               cyc <= cyc + 1'b1;
               if (cyc == CW'(CONVST_CYC - 1)) begin
                  ad_convst <= 1'b1;
                  seen_busy <= 1'b0;
                  cyc <= '0;
                  state <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               cyc <= cyc + 1'b1;
               if (ad_busy) seen_busy <= 1'b1;
               // busy fall wins over a timeout landing on the same cycle
               if (seen_busy && !ad_busy) begin
                  ad_cs <= 1'b0;
                  ad_rd <= 1'b0;
                  chan <= '0;
                  cyc <= '0;
                  state <= ST_RD_LO;
               end else if (cyc == CW'(BUSY_TO - 1)) begin
                  frame_err <= 1'b1;
                  cyc <= '0;
                  state <= ST_IDLE;
               end
            end
            ST_RD_LO: begin
               cyc <= cyc + 1'b1;
               if (cyc == CW'(RD_CYC - 1)) begin
                  m.data <= ad_data;
                  m.chan <= chan;
                  m.last <= chan == CH_W'(NUM_CH - 1);
                  m.valid <= 1'b1;
                  if (chan == '0 && !ad_first_data) frame_err <= 1'b1;
                  ad_rd <= 1'b1;
                  cyc <= '0;
                  state <= ST_RD_HI;
               end
            end
            ST_RD_HI:
               // the high phase stretches until the previous word has been taken
               if (cyc != CW'(RD_CYC - 1)) cyc <= cyc + 1'b1;
               else if (!stall) begin
                  cyc <= '0;
                  if (chan == CH_W'(NUM_CH - 1)) begin
                     ad_cs <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     chan <= chan + 1'b1;
                     ad_rd <= 1'b0;
                     state <= ST_RD_LO;
                  end
               end
            default: state <= ST_RST;
         endcase
      end
endmodule

// File: doc/adc_par_sampler.md
ADC_PAR_SAMPLER -- requirements
Module: adc_par_sampler

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of ADC channels read per conversion (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, ADC sample width.
REQ-003 SHALL have parameter CONV_PERIOD, default 1000, clk cycles between conversion requests (>= 64).
REQ-004 SHALL have parameter RD_CYC, default 4, clk cycles of each ad_rd low phase and each high phase.
REQ-005 SHALL have parameter BUSY_TO, default 4096, clk cycles allowed from convst release to busy fall.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 enable  in  1  allows conversion requests.
REQ-010 os_sel  in  3  oversampling ratio code, latched at conversion start.
REQ-011 ad_data  in  DATA_W  parallel ADC data bus.
REQ-012 ad_busy  in  1  ADC conversion busy.
REQ-013 ad_first_data  in  1  ADC marker, high while channel 0 is on the bus.
REQ-014 ad_os  out  3  oversampling pins.
REQ-015 ad_reset  out  1  ADC reset, active high.
REQ-016 ad_convst  out  1  conversion start, active-low pulse.
REQ-017 ad_cs  out  1  chip select, active low.
REQ-018 ad_rd  out  1  read strobe, active low.
REQ-019 m_data  out  DATA_W  sample stream data.
REQ-020 m_chan  out  max(1,$clog2(NUM_CH))  channel index of m_data.
REQ-021 m_last  out  1  high on the last channel of a frame.
REQ-022 m_valid  out  1  stream valid.
REQ-023 m_ready  in  1  stream ready; transfer occurs when m_valid and m_ready are both high.
REQ-024 overrun  out  1  sticky: conversion tick occurred while not idle.
REQ-025 frame_err  out  1  sticky: busy timeout or first_data missing on channel 0.

Function
REQ-026 SHALL use FSM states ST_RST, ST_IDLE, ST_CONV, ST_WAIT_BUSY, ST_RD_LO, ST_RD_HI.
REQ-027 ST_RST SHALL hold ad_reset high for RST_CYC=4 cycles, then go to ST_IDLE.
REQ-028 Period counter SHALL count 0..CONV_PERIOD-1 while enable is high, wrap, and emit tick at wrap; it SHALL be held at 0 while enable is low.
REQ-029 ST_IDLE with tick SHALL latch os_sel into ad_os and go to ST_CONV; a tick in any other state SHALL set overrun, and that conversion is skipped.
REQ-030 ST_CONV SHALL drive ad_convst low for exactly 2 cycles, then go to ST_WAIT_BUSY.
REQ-031 ST_WAIT_BUSY SHALL wait for an ad_busy high then low; on busy fall go to ST_RD_LO with channel=0 and ad_cs low.
REQ-032 If BUSY_TO cycles elapse in ST_WAIT_BUSY, the block SHALL set frame_err and return to ST_IDLE, with no stream output.
REQ-033 ST_RD_LO SHALL drive ad_rd low for RD_CYC cycles and capture ad_data and ad_first_data on the last low cycle.
REQ-034 The captured word SHALL appear on m_data with m_valid high the next cycle, m_chan=channel, and m_last=(channel==NUM_CH-1).
REQ-035 A channel-0 capture with ad_first_data low SHALL set frame_err; the data SHALL still be delivered.
REQ-036 ST_RD_HI SHALL drive ad_rd high for at least RD_CYC cycles, extending while m_valid is high and m_ready is low (backpressure stalls reads, no data lost).
REQ-037 After the last channel's ST_RD_HI, the block SHALL raise ad_cs and go to ST_IDLE; otherwise it SHALL increment channel and go to ST_RD_LO.
REQ-038 m_valid SHALL stay high with m_data, m_chan and m_last stable until the transfer occurs.
REQ-039 enable falling mid-frame SHALL let the frame complete, with no new conversion afterwards.
REQ-040 Idle output levels SHALL be ad_convst=1, ad_cs=1, ad_rd=1.

Reset
REQ-041 rst SHALL force ST_RST and set ad_reset=1, ad_convst=1, ad_cs=1, ad_rd=1, ad_os=0, m_valid=0, m_data=0, m_chan=0, m_last=0, overrun=0, frame_err=0, all counters=0.
REQ-042 rst asserted mid-frame SHALL abort immediately; the sticky flags are cleared only by rst.

Structure
REQ-043 Package adc_pkg SHALL hold the FSM state enum, RST_CYC and CONVST_CYC constants.
REQ-044 The period/tick generator SHALL be a sub-module, adc_rate_tick.

Verification
REQ-045 NUM_CH=8, m_ready=1, ADC model with busy 50 cycles and data=0x1000+ch -> 8 words 0x1000..0x1007, m_last on ch 7, no flags set.
REQ-046 m_ready held low 100 cycles after first word -> ad_rd stays high; all 8 words are delivered in order after release.
REQ-047 ADC busy is never asserted -> frame_err=1 after 4096 cycles, no m_valid, FSM back in idle.
REQ-048 CONV_PERIOD=64 with m_ready low long -> overrun=1; the current frame still completes intact.
REQ-049 ad_first_data low on ch 0 -> frame_err=1, word delivered; os_sel=3 at tick -> ad_os=3.
REQ-050 rst pulse during ch 3 read -> the next cycle shows ad_cs=1, m_valid=0, ad_reset=1 for 4 cycles.
